// File: rtl/tx_pll_lock_pkg.sv
// Shared channel state encoding and default parameters for the TX PLL lock manager.
package tx_pll_lock_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_READY     = 2'd2,
    ST_LOST      = 2'd3
  } chan_state_e;

  localparam int unsigned DEF_N_PLL          = 1;
  localparam int unsigned DEF_LOCK_CYCLES    = 1024;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_CNT_W          = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_pll_lock_chan.sv
// One supervised PLL: 2-flop lock synchroniser, lock qualification FSM, LOL/timeout status.
// Raw lock edge reaches the FSM after 2 cycles; all outputs are registered.
module tx_pll_lock_chan
  import tx_pll_lock_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pll_lock_i,
  input  logic             clr_sticky_i,
  output logic             lane_rst_n_o,
  output logic             pll_ready_o,
  output logic             ready_nxt_o,
  output logic             lol_sticky_o,
  output logic [CNT_W-1:0] lol_count_o,
  output logic             timeout_o
);

  localparam int unsigned QW = cnt_width(LOCK_CYCLES);
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [QW-1:0]    QMAX = QW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LMAX = {CNT_W{1'b1}};

  logic             sync1_q, lock_q;
  chan_state_e      state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             timeout_q, timeout_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             ready_q, lane_rst_n_q;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    tcnt_d    = tcnt_q;
    // Clear is applied first so a same-cycle loss of lock still records one event.
    sticky_d  = clr_sticky_i ? 1'b0 : sticky_q;
    lcnt_d    = clr_sticky_i ? '0 : lcnt_q;
    timeout_d = clr_sticky_i ? 1'b0 : timeout_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_q) begin
          state_d = ST_QUALIFY;
          qcnt_d  = '0;
        end else if (tcnt_q == TMAX) begin
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_QUALIFY: begin
        if (!lock_q) begin
          state_d = ST_WAIT_LOCK;
          tcnt_d  = '0;
        end else if (qcnt_q == QMAX) begin
          state_d   = ST_READY;
          timeout_d = 1'b0;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (!lock_q) begin
          state_d  = ST_LOST;
          sticky_d = 1'b1;
          if (lcnt_d != LMAX) lcnt_d = lcnt_d + 1'b1;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
        qcnt_d  = '0;
        tcnt_d  = '0;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q      <= 1'b0;
      lock_q       <= 1'b0;
      state_q      <= ST_WAIT_LOCK;
      qcnt_q       <= '0;
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
      sticky_q     <= 1'b0;
      lcnt_q       <= '0;
      ready_q      <= 1'b0;
      lane_rst_n_q <= 1'b0;
    end else begin
      sync1_q      <= pll_lock_i;
      lock_q       <= sync1_q;
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      tcnt_q       <= tcnt_d;
      timeout_q    <= timeout_d;
      sticky_q     <= sticky_d;
      lcnt_q       <= lcnt_d;
      ready_q      <= (state_d == ST_READY);
      lane_rst_n_q <= (state_d == ST_READY);
    end
  end

  assign ready_nxt_o  = rst_n_i && (state_d == ST_READY);
  assign pll_ready_o  = ready_q;
  assign lane_rst_n_o = lane_rst_n_q;
  assign lol_sticky_o = sticky_q;
  assign lol_count_o  = lcnt_q;
  assign timeout_o    = timeout_q;

endmodule

// File: rtl/tx_pll_lock_mgr.sv
// Supervises N_PLL TX PLLs, releasing lane resets only after qualified lock.
// ALL_READY is registered from the channels' next-state so it tracks PLL_READY exactly.
module tx_pll_lock_mgr
  import tx_pll_lock_pkg::*;
#(
  parameter int unsigned N_PLL          = DEF_N_PLL,
  parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [N_PLL-1:0]       PLL_LOCK,
  input  logic                   CLR_STICKY,
  output logic [N_PLL-1:0]       LANE_RST_N,
  output logic [N_PLL-1:0]       PLL_READY,
  output logic                   ALL_READY,
  output logic [N_PLL-1:0]       LOL_STICKY,
  output logic [N_PLL*CNT_W-1:0] LOL_COUNT,
  output logic [N_PLL-1:0]       TIMEOUT
);

  logic [N_PLL-1:0] ready_nxt;
  logic             all_ready_q;

  for (genvar i = 0; i < N_PLL; i++) begin : g_chan
    tx_pll_lock_chan #(
      .LOCK_CYCLES   (LOCK_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk_i       (CLK),
      .rst_n_i     (RESETN),
      .pll_lock_i  (PLL_LOCK[i]),
      .clr_sticky_i(CLR_STICKY),
      .lane_rst_n_o(LANE_RST_N[i]),
      .pll_ready_o (PLL_READY[i]),
      .ready_nxt_o (ready_nxt[i]),
      .lol_sticky_o(LOL_STICKY[i]),
      .lol_count_o (LOL_COUNT[i*CNT_W +: CNT_W]),
      .timeout_o   (TIMEOUT[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) all_ready_q <= 1'b0;
    else         all_ready_q <= &ready_nxt;
  end

  assign ALL_READY = all_ready_q;

endmodule

// File: tb/tb_tx_pll_lock_mgr.sv
module tb_tx_pll_lock_mgr;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [1:0] PLL_LOCK = 2'b00;
  logic       CLR_STICKY = 1'b0;
  logic [1:0] LANE_RST_N, PLL_READY, LOL_STICKY, TIMEOUT;
  logic       ALL_READY;
  logic [7:0] LOL_COUNT;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  tx_pll_lock_mgr #(
    .N_PLL(2), .LOCK_CYCLES(16), .TIMEOUT_CYCLES(64), .CNT_W(4)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .CLR_STICKY(CLR_STICKY),
    .LANE_RST_N(LANE_RST_N), .PLL_READY(PLL_READY), .ALL_READY(ALL_READY),
    .LOL_STICKY(LOL_STICKY), .LOL_COUNT(LOL_COUNT), .TIMEOUT(TIMEOUT)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESETN = 1'b0; PLL_LOCK = 2'b11; step(4);
    n_total++; if (PLL_READY !== 2'b00) $display("FAIL reset_ready: got %b expected 00", PLL_READY); else n_pass++;
    n_total++; if (LANE_RST_N !== 2'b00) $display("FAIL reset_lane_rst: got %b expected 00", LANE_RST_N); else n_pass++;
    n_total++; if (ALL_READY !== 1'b0) $display("FAIL reset_all_ready: got %b expected 0", ALL_READY); else n_pass++;
    PLL_LOCK = 2'b00; step(2);
    n_total++; if (LOL_STICKY !== 2'b00) $display("FAIL reset_sticky: got %b expected 00", LOL_STICKY); else n_pass++;
    n_total++; if (LOL_COUNT !== 8'h00) $display("FAIL reset_count: got %h expected 00", LOL_COUNT); else n_pass++;
    n_total++; if (TIMEOUT !== 2'b00) $display("FAIL reset_timeout: got %b expected 00", TIMEOUT); else n_pass++;
    RESETN = 1'b1; step(1);
  endtask

  // 2 sync + 1 WAIT->QUALIFY + 16 qualify cycles = 19 edges from the raw edge
  task automatic test_lock_qualify;
    PLL_LOCK[0] = 1'b1; step(18);
    n_total++; if (PLL_READY[0] !== 1'b0) $display("FAIL qual_early_ready: got %b expected 0", PLL_READY[0]); else n_pass++;
    n_total++; if (LANE_RST_N[0] !== 1'b0) $display("FAIL qual_early_lane: got %b expected 0", LANE_RST_N[0]); else n_pass++;
    step(1);
    n_total++; if (PLL_READY[0] !== 1'b1) $display("FAIL qual_ready: got %b expected 1", PLL_READY[0]); else n_pass++;
    n_total++; if (LANE_RST_N[0] !== 1'b1) $display("FAIL qual_lane: got %b expected 1", LANE_RST_N[0]); else n_pass++;
    n_total++; if (ALL_READY !== 1'b0) $display("FAIL qual_all_ready: got %b expected 0", ALL_READY); else n_pass++;
  endtask

  // Channel 1 has sat in WAIT_LOCK since reset release; 20 edges elapsed so far.
  task automatic test_timeout;
    step(43);
    n_total++; if (TIMEOUT !== 2'b00) $display("FAIL timeout_early: got %b expected 00", TIMEOUT); else n_pass++;
    step(1);
    n_total++; if (TIMEOUT !== 2'b10) $display("FAIL timeout_set: got %b expected 10", TIMEOUT); else n_pass++;
    step(5);
    n_total++; if (TIMEOUT !== 2'b10) $display("FAIL timeout_hold: got %b expected 10", TIMEOUT); else n_pass++;
    n_total++; if (PLL_READY !== 2'b01) $display("FAIL timeout_ready: got %b expected 01", PLL_READY); else n_pass++;
    PLL_LOCK[1] = 1'b1; step(18);
    n_total++; if (PLL_READY[1] !== 1'b0 || TIMEOUT[1] !== 1'b1) $display("FAIL timeout_pre_ready: got ready=%b timeout=%b expected 0 1", PLL_READY[1], TIMEOUT[1]); else n_pass++;
    step(1);
    n_total++; if (PLL_READY !== 2'b11) $display("FAIL timeout_ready_after: got %b expected 11", PLL_READY); else n_pass++;
    n_total++; if (TIMEOUT !== 2'b00) $display("FAIL timeout_cleared: got %b expected 00", TIMEOUT); else n_pass++;
    n_total++; if (ALL_READY !== 1'b1) $display("FAIL all_ready: got %b expected 1", ALL_READY); else n_pass++;
  endtask

  task automatic test_glitch;
    PLL_LOCK[0] = 1'b0; step(1); PLL_LOCK[0] = 1'b1; step(2);
    n_total++; if (PLL_READY !== 2'b10) $display("FAIL glitch_ready: got %b expected 10", PLL_READY); else n_pass++;
    n_total++; if (LANE_RST_N !== 2'b10) $display("FAIL glitch_lane: got %b expected 10", LANE_RST_N); else n_pass++;
    n_total++; if (ALL_READY !== 1'b0) $display("FAIL glitch_all_ready: got %b expected 0", ALL_READY); else n_pass++;
    n_total++; if (LOL_COUNT !== 8'h01) $display("FAIL glitch_count: got %h expected 01", LOL_COUNT); else n_pass++;
    n_total++; if (LOL_STICKY !== 2'b01) $display("FAIL glitch_sticky: got %b expected 01", LOL_STICKY); else n_pass++;
    step(17);
    n_total++; if (PLL_READY[0] !== 1'b0) $display("FAIL requal_early: got %b expected 0", PLL_READY[0]); else n_pass++;
    step(1);
    n_total++; if (PLL_READY[0] !== 1'b1 || ALL_READY !== 1'b1) $display("FAIL requal_ready: got ready=%b all=%b expected 1 1", PLL_READY[0], ALL_READY); else n_pass++;
  endtask

  task automatic test_lol_saturate;
    for (int k = 0; k < 19; k++) begin
      PLL_LOCK[0] = 1'b0; step(1); PLL_LOCK[0] = 1'b1; step(2);
      for (int c = 0; c < 40 && PLL_READY[0] !== 1'b1; c++) step(1);
      n_total++; if (PLL_READY[0] !== 1'b1) $display("FAIL sat_recover_%0d: got %b expected 1", k, PLL_READY[0]); else n_pass++;
    end
    n_total++; if (LOL_COUNT !== 8'h0F) $display("FAIL sat_count: got %h expected 0f", LOL_COUNT); else n_pass++;
    n_total++; if (LOL_STICKY !== 2'b01) $display("FAIL sat_sticky: got %b expected 01", LOL_STICKY); else n_pass++;
  endtask

  task automatic test_clr_sticky;
    PLL_LOCK[0] = 1'b0; step(1); PLL_LOCK[0] = 1'b1; step(1);
    CLR_STICKY = 1'b1; step(1); CLR_STICKY = 1'b0;
    n_total++; if (PLL_READY[0] !== 1'b0) $display("FAIL clr_same_lost: got %b expected 0", PLL_READY[0]); else n_pass++;
    n_total++; if (LOL_COUNT !== 8'h01) $display("FAIL clr_same_count: got %h expected 01", LOL_COUNT); else n_pass++;
    n_total++; if (LOL_STICKY !== 2'b01) $display("FAIL clr_same_sticky: got %b expected 01", LOL_STICKY); else n_pass++;
    for (int c = 0; c < 40 && PLL_READY[0] !== 1'b1; c++) step(1);
    n_total++; if (PLL_READY[0] !== 1'b1) $display("FAIL clr_recover: got %b expected 1", PLL_READY[0]); else n_pass++;
    CLR_STICKY = 1'b1; step(1); CLR_STICKY = 1'b0;
    n_total++; if (LOL_COUNT !== 8'h00 || LOL_STICKY !== 2'b00) $display("FAIL clr_plain: got count=%h sticky=%b expected 00 00", LOL_COUNT, LOL_STICKY); else n_pass++;
  endtask

  task automatic test_toggle;
    logic seen;
    seen = 1'b0;
    RESETN = 1'b0; PLL_LOCK = 2'b00; step(3); RESETN = 1'b1;
    for (int p = 0; p < 20; p++) begin
      PLL_LOCK[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin step(1); seen = seen | PLL_READY[0]; end
      PLL_LOCK[0] = 1'b0;
      for (int c = 0; c < 5; c++) begin step(1); seen = seen | PLL_READY[0]; end
    end
    n_total++; if (seen !== 1'b0) $display("FAIL toggle_ready: got %b expected 0", seen); else n_pass++;
    n_total++; if (TIMEOUT !== 2'b10) $display("FAIL toggle_timeout: got %b expected 10", TIMEOUT); else n_pass++;
  endtask

  task automatic test_reset_midqual;
    PLL_LOCK[0] = 1'b1; step(13);
    n_total++; if (PLL_READY[0] !== 1'b0) $display("FAIL midq_pre: got %b expected 0", PLL_READY[0]); else n_pass++;
    RESETN = 1'b0; step(2);
    n_total++; if (LANE_RST_N !== 2'b00 || PLL_READY !== 2'b00) $display("FAIL midq_in_reset: got lane=%b ready=%b expected 00 00", LANE_RST_N, PLL_READY); else n_pass++;
    RESETN = 1'b1; step(18);
    n_total++; if (PLL_READY[0] !== 1'b0) $display("FAIL midq_early: got %b expected 0", PLL_READY[0]); else n_pass++;
    step(1);
    n_total++; if (PLL_READY[0] !== 1'b1) $display("FAIL midq_ready: got %b expected 1", PLL_READY[0]); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_lock_qualify;
    test_timeout;
    test_glitch;
    test_lol_saturate;
    test_clr_sticky;
    test_toggle;
    test_reset_midqual;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_pll_lock_mgr.md
TX_PLL_LOCK_MGR -- requirements
Module: tx_pll_lock_mgr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named CLK and RESETN.
REQ-002 Parameter N_PLL, default 1: number of supervised TX PLLs, range 1..4.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive synchronised-lock cycles required to qualify lock, range 2..2^20.
REQ-004 Parameter TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before TIMEOUT, range 4..2^24.
REQ-005 Parameter CNT_W, default 8: width of each loss-of-lock counter.
REQ-006 CLK  in  1  free-running fabric clock (125 MHz divided PLL clock or fabric clock).
REQ-007 RESETN  in  1  synchronous active-low reset.
REQ-008 PLL_LOCK  in  N_PLL  raw PLL lock indications, asynchronous to CLK.
REQ-009 CLR_STICKY  in  1  single-cycle pulse; clears LOL_STICKY, LOL_COUNT and TIMEOUT for all channels.
REQ-010 LANE_RST_N  out  N_PLL  active-low reset to the lanes fed by each PLL.
REQ-011 PLL_READY  out  N_PLL  qualified lock per channel.
REQ-012 ALL_READY  out  1  AND of PLL_READY.
REQ-013 LOL_STICKY  out  N_PLL  loss-of-lock seen since last clear.
REQ-014 LOL_COUNT  out  N_PLL*CNT_W  per-channel loss-of-lock count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-015 TIMEOUT  out  N_PLL  lock not qualified within TIMEOUT_CYCLES.

Function
REQ-016 Each PLL_LOCK bit SHALL pass through a 2-flop synchroniser; all logic below uses the synchronised value L.
REQ-017 Each channel SHALL run an independent FSM with states WAIT_LOCK, QUALIFY, READY and LOST.
REQ-018 WAIT_LOCK: LANE_RST_N=0; if L=1, go to QUALIFY with the qualify counter cleared; otherwise increment the timeout counter.
REQ-019 WAIT_LOCK: when the timeout counter reaches TIMEOUT_CYCLES-1, TIMEOUT SHALL set; the counter SHALL saturate there, and the FSM SHALL stay in WAIT_LOCK.
REQ-020 QUALIFY: LANE_RST_N=0; if L=0, go to WAIT_LOCK with the timeout counter cleared; otherwise increment the qualify counter.
REQ-021 QUALIFY: after LOCK_CYCLES consecutive cycles with L=1, the FSM SHALL enter READY on the next edge.
REQ-022 READY: PLL_READY=1 and LANE_RST_N=1; if L=0, go to LOST.
REQ-023 LOST lasts exactly one cycle with LANE_RST_N=0 and PLL_READY=0, then enters WAIT_LOCK with the counters cleared.
REQ-024 On entry to LOST, LOL_STICKY SHALL set and LOL_COUNT SHALL increment, saturating at 2^CNT_W-1.
REQ-025 Entry to READY SHALL clear that channel's TIMEOUT.
REQ-026 If CLR_STICKY and a LOST entry occur in the same cycle, the clear applies first: LOL_COUNT=1 and LOL_STICKY=1.
REQ-027 PLL_READY, LANE_RST_N and ALL_READY SHALL be registered outputs.
REQ-028 Latency from a raw PLL_LOCK edge to the FSM seeing it SHALL be 2 cycles.
REQ-029 A single-cycle L=0 glitch during READY SHALL be treated as a full loss of lock.

Reset
REQ-030 While RESETN=0 at a clock edge, every FSM SHALL go to WAIT_LOCK and all counters, synchroniser flops, LOL_STICKY, LOL_COUNT and TIMEOUT SHALL clear.
REQ-031 While in reset: LANE_RST_N=0, PLL_READY=0 and ALL_READY=0.
REQ-032 Reset asserted mid-qualification or in READY SHALL restart qualification from zero after release.

Structure
REQ-033 Package tx_pll_lock_pkg SHALL hold the channel state enum and the default parameter constants.
REQ-034 Sub-module tx_pll_lock_chan SHALL implement one channel (synchroniser, FSM, counters); the top SHALL instantiate N_PLL copies and form ALL_READY.

Verification
REQ-035 Use N_PLL=2, LOCK_CYCLES=16, TIMEOUT_CYCLES=64, CNT_W=4. Raise PLL_LOCK[0] and hold it -> PLL_READY[0] and LANE_RST_N[0] rise 2+16+1 cycles later; ALL_READY stays 0.
REQ-036 PLL_LOCK[1] held low -> TIMEOUT[1] sets after 64 cycles in WAIT_LOCK; later a stable lock -> READY and TIMEOUT[1]=0.
REQ-037 Drop lock for 1 cycle during READY -> LOST for 1 cycle, LOL_COUNT=1, LOL_STICKY=1, then requalification takes 16 cycles.
REQ-038 Cause 20 losses of lock -> LOL_COUNT saturates at 15; CLR_STICKY issued in the same cycle as a loss -> LOL_COUNT=1.
REQ-039 Lock toggles with a period of 10 cycles during QUALIFY -> PLL_READY never asserts and TIMEOUT does not set.
REQ-040 Assert RESETN=0 at qualify count 10 -> after release, the full 16-cycle qualification is required.
